fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, PC value loaded on reset; multiple of 4.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-005 SHALL have port imem_addr  output  64  byte address of the requested word; equals pc.
REQ-006 SHALL have port imem_ack  input  1  memory has returned imem_rdata this cycle.
REQ-007 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port instr  output  32  held instruction, to decoder (opcode = instr[31:21]).
REQ-009 SHALL have port instr_valid  output  1  instr holds a fetched, unretired instruction.
REQ-010 SHALL have port instr_ready  input  1  datapath retires instr this cycle.
REQ-011 SHALL have ports UBranch, Branch, Brsel  input  1 each  control-unit outputs for the held instr.
REQ-012 SHALL have ports zero, flag_n, flag_v  input  1 each  ALU zero (CBZ) and stored N/V flags (BLT).
REQ-013 SHALL have port pc  output  64  address of the held or in-flight instruction.

Function
REQ-014 SHALL implement two states: FETCH (imem_req=1) and HOLD (instr_valid=1); never both asserted.
REQ-015 SHALL, in FETCH with imem_ack=1, register imem_rdata into instr and enter HOLD next cycle (1-cycle latency from ack to instr_valid).
REQ-016 SHALL accept ack in the same cycle imem_req first rises (zero-wait memory); wait indefinitely otherwise.
REQ-017 SHALL ignore imem_ack and imem_rdata whenever imem_req=0.
REQ-018 SHALL keep instr, pc stable throughout HOLD until instr_valid&instr_ready.
REQ-019 SHALL ignore instr_ready in FETCH.
REQ-020 SHALL, on retire (HOLD & instr_ready), compute taken = UBranch | (Branch & (Brsel ? (flag_n ^ flag_v) : zero)).
REQ-021 SHALL use offset = sign-extended instr[25:0] if UBranch, else sign-extended instr[23:5]; next pc = pc + (offset<<2) if taken, else pc + 4.
REQ-022 SHALL load next pc and return to FETCH in the cycle after retire; imem_addr shows new pc that cycle.
REQ-023 SHALL treat UBranch and Branch both high as unconditional (UBranch priority).
REQ-024 SHALL perform all PC arithmetic modulo 2^64 (wrap-around, no fault); offset 0 taken = self-loop.
REQ-025 SHALL sample branch/flag inputs only in the retire cycle; values in other cycles have no effect.

Reset
REQ-026 SHALL, while reset=1, hold pc=RESET_PC, instr=32'h0, instr_valid=0, imem_req=0, state=FETCH.
REQ-027 SHALL assert imem_req with imem_addr=RESET_PC in the first cycle after reset deasserts.
REQ-028 SHALL abandon any in-flight fetch or held instruction on reset; an ack during reset is discarded.
REQ-029 SHALL give reset priority over ack and retire in the same cycle.

Structure
REQ-030 SHALL take opcode patterns (B, BLT, CBZ), XLEN=64, ILEN=32 and the state enum from shared package cpu_pkg.
REQ-031 SHALL place offset select, sign extension, shift and adder in combinational sub-module pc_next (inputs pc, instr, taken, UBranch; output next_pc).

Verification
REQ-032 Reset, zero-wait memory, three non-branch instrs retired immediately -> imem_addr 0x0, 0x4, 0x8; each instr_valid one cycle after ack.
REQ-033 Memory acks 3 cycles after req -> imem_req stays high 4 cycles, instr_valid low until cycle after ack, addr unchanged.
REQ-034 pc=0x100, instr B imm26=-2, UBranch=1, retire -> next imem_addr 0x0F8.
REQ-035 pc=0x40, CBZ imm19=+3: zero=1 -> 0x4C; zero=0 -> 0x44. BLT imm19=+3: n=1,v=0 -> 0x4C; n=1,v=1 -> 0x44.
REQ-036 HOLD with instr_ready low 5 cycles, then high -> instr/pc stable all 5 cycles, single advance.
REQ-037 reset asserted during FETCH with ack same cycle -> instr stays 0, restart at RESET_PC; pc=2^64-4 non-branch retire -> next pc 0x0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: machine widths, fetch FSM states and the
// control-flow opcode patterns the decoder matches on instr[31:21].
package cpu_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  // Opcode patterns on instr[31:21]; '?' bits are immediate or condition fields.
  localparam logic [10:0] OP_B   = 11'b000101?????;
  localparam logic [10:0] OP_BLT = 11'b01010100???;
  localparam logic [10:0] OP_CBZ = 11'b10110100???;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_next.sv
// Next-PC computation: picks the branch immediate, sign-extends it, scales it
// to bytes and adds it to pc (modulo 2^64), or falls through to pc + 4.
module pc_next
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [ILEN-1:0] instr,
  input  logic            taken,
  input  logic            UBranch,
  output logic [XLEN-1:0] next_pc
);

  logic signed [XLEN-1:0] offset;
  logic        [XLEN-1:0] target;
  logic                   unused_instr_bits;

  // Unconditional B carries imm26; CBZ/B.cond carry imm19 in [23:5].
  always_comb begin
    if (UBranch) begin
      offset = XLEN'($signed(instr[25:0]));
    end else begin
      offset = XLEN'($signed(instr[23:5]));
    end
  end

  assign target  = pc + XLEN'(offset <<< 2);
  assign next_pc = taken ? target : pc + XLEN'(4);

  assign unused_instr_bits = ^{instr[31:26]};

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: requests the word at pc, holds it for the datapath until
// it retires, then advances pc by 4 or to the resolved branch target.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [ILEN-1:0] instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            UBranch,
  input  logic            Branch,
  input  logic            Brsel,
  input  logic            zero,
  input  logic            flag_n,
  input  logic            flag_v,
  output logic [XLEN-1:0] pc
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] next_pc;
  logic            taken;

  assign taken = UBranch | (Branch & (Brsel ? (flag_n ^ flag_v) : zero));

  pc_next u_pc_next (
    .pc      (pc_q),
    .instr   (instr_q),
    .taken   (taken),
    .UBranch (UBranch),
    .next_pc (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Branch and flag inputs only matter here, on the retire edge.
        if (instr_ready) begin
          pc_d    = next_pc;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Handshakes are masked during reset so nothing is requested or presented.
  assign imem_req    = (state_q == ST_FETCH) & ~reset;
  assign instr_valid = (state_q == ST_HOLD) & ~reset;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;

endmodule
